fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage and its queue.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush drops everything in one cycle.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push_i,
  input  fetch_entry_t     entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = advance(wr_ptr_q);
      if (do_pop)  rd_ptr_d = advance(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while the count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order word fetches under a credit limit and
// queues responses for decode, discarding stale responses after a redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             halt_q, halt_d;
  logic             pending_q, pending_d;
  logic             run_q;

  logic             fire, stale, push, pop, room;
  logic [CNT_W:0]   in_use;
  fetch_entry_t     push_entry, head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, fifo_full;

  assign fire   = imem_req && imem_gnt;
  assign stale  = redirect || (drop_q != '0);
  assign push   = imem_rvalid && !stale;
  assign pop    = !fifo_empty && !stall && !redirect;
  assign in_use = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign room   = !fifo_full && (in_use < (CNT_W + 1)'(DEPTH));

  // A request already on the bus stays up until granted, even if a fault halts
  // fetch meanwhile; only a redirect may withdraw it.
  assign imem_req  = run_q && !redirect && (pending_q || (!halt_q && room));
  assign imem_addr = fetch_pc_q;

  assign push_entry = '{instr: imem_rdata, pc: resp_pc_q, fault: imem_err};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect),
    .head_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? head.pc    : 32'h0000_0000;
  assign instr_fault = instr_valid && head.fault;

  // Responses return in order, and every live request since the last redirect
  // was contiguous, so the pc of the next kept response is a running counter.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(imem_rvalid);
    drop_d        = drop_q;
    halt_d        = halt_q;
    pending_d     = imem_req && !imem_gnt;
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      drop_d     = outstanding_q - CNT_W'(imem_rvalid);
      halt_d     = 1'b0;
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) resp_pc_d = resp_pc_q + 32'd4;
      if (imem_rvalid && drop_q != '0) drop_d = drop_q - CNT_W'(1);
      if (push && imem_err) halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      halt_q        <= 1'b0;
      pending_q     <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      halt_q        <= halt_d;
      pending_q     <= pending_d;
      run_q         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a bench-side memory answers granted fetches
// with in-order responses, and a queue-level model predicts the decode stream.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk, nrst;
  logic        imem_req, imem_gnt, imem_rvalid, imem_err;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect, stall;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_fault;
  logic [31:0] instr, instr_pc;

  fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_fault (instr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One entry per granted fetch still in flight; stale marks fetches made
  // before the most recent redirect.
  typedef struct {
    logic [31:0] addr;
    logic        err;
    int          ready;
    bit          stale;
  } flight_t;

  flight_t      flight[$];
  fetch_entry_t expq[$];
  logic [31:0]  pcM;
  bit           haltM, pendM, runM;
  int           cyc;
  int           checkCount, errorCount;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, observed, expected);
    end
  endtask

  function automatic logic [31:0] instrFor(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic logic [31:0] pickTarget();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0103;
      1:       return 32'hFFFF_FFFC;
      2:       return 32'hFFFF_FFF8;
      default: return $urandom;
    endcase
  endfunction

  task automatic driveIdle();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_err    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
  endtask

  // Entered and left at a falling edge; memory and model restart with the DUT.
  task automatic applyReset(input int cycles);
    nrst = 1'b0;
    driveIdle();
    flight.delete();
    expq.delete();
    pcM   = RPC;
    haltM = 0;
    pendM = 0;
    runM  = 0;
    #1;
    checkOutput("rst_imem_req", 32'(imem_req), 0);
    checkOutput("rst_imem_addr", imem_addr, RPC);
    checkOutput("rst_instr_valid", 32'(instr_valid), 0);
    checkOutput("rst_instr", instr, NOP_INSTR);
    checkOutput("rst_instr_pc", instr_pc, 0);
    checkOutput("rst_instr_fault", 32'(instr_fault), 0);
    repeat (cycles) @(negedge clk);
    nrst = 1'b1;
  endtask

  // One clock cycle: check outputs, drive random inputs, check the request,
  // then advance the model at the rising edge.
  task automatic applyStimulus(input int gntPct, input int rvPct, input int stallPct,
                               input int redirPct, input int errPct, input int maxLat);
    bit      rv, reqExp, fire, popM;
    flight_t f;
    logic [31:0] target;

    if (expq.size() > 0) begin
      checkOutput("instr_valid", 32'(instr_valid), 1);
      checkOutput("instr", instr, expq[0].instr);
      checkOutput("instr_pc", instr_pc, expq[0].pc);
      checkOutput("instr_fault", 32'(instr_fault), 32'(expq[0].fault));
    end else begin
      checkOutput("instr_valid", 32'(instr_valid), 0);
      checkOutput("instr_nop", instr, NOP_INSTR);
      checkOutput("instr_pc_idle", instr_pc, 0);
      checkOutput("instr_fault_idle", 32'(instr_fault), 0);
    end

    target      = pickTarget();
    redirect    = pct(redirPct);
    redirect_pc = target;
    stall       = pct(stallPct);
    imem_gnt    = pct(gntPct);
    rv          = (flight.size() > 0) && (flight[0].ready <= cyc) && pct(rvPct);
    imem_rvalid = rv;
    if (rv) begin
      imem_rdata = instrFor(flight[0].addr);
      imem_err   = flight[0].err;
    end else begin
      imem_rdata = $urandom;
      imem_err   = pct(50);
    end
    assert (!(imem_rvalid && flight.size() == 0));
    #1;

    reqExp = runM && !redirect && (pendM || (!haltM && (flight.size() + expq.size() < DEPTH)));
    checkOutput("imem_req", 32'(imem_req), 32'(reqExp));
    if (reqExp) checkOutput("imem_addr", imem_addr, pcM);
    fire = reqExp && imem_gnt;
    popM = (expq.size() > 0) && !stall && !redirect;

    @(posedge clk);
    if (rv) f = flight.pop_front();
    if (popM) void'(expq.pop_front());
    if (redirect) begin
      expq.delete();
      foreach (flight[i]) flight[i].stale = 1;
      pcM   = {redirect_pc[31:2], 2'b00};
      haltM = 0;
    end else if (rv && !f.stale) begin
      expq.push_back('{instr: instrFor(f.addr), pc: f.addr, fault: f.err});
      if (f.err) haltM = 1;
    end
    if (fire) begin
      flight.push_back('{addr: pcM, err: pct(errPct), ready: cyc + 1 + $urandom_range(0, maxLat), stale: 0});
      pcM = pcM + 32'd4;
    end
    pendM = reqExp && !imem_gnt;
    runM  = 1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic runPhase(input int n, input int gntPct, input int rvPct, input int stallPct,
                          input int redirPct, input int errPct, input int maxLat);
    for (int i = 0; i < n; i++) applyStimulus(gntPct, rvPct, stallPct, redirPct, errPct, maxLat);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    cyc        = 0;
    nrst       = 1'b0;
    driveIdle();
    @(negedge clk);
    applyReset(3);

    // Streaming with immediate grants and one-cycle responses.
    runPhase(40, 100, 100, 0, 0, 0, 0);
    // Heavy stall to hold the queue full.
    runPhase(40, 100, 100, 90, 0, 0, 1);
    // Mixed traffic with redirects and faults.
    runPhase(600, 70, 80, 30, 5, 5, 3);
    runPhase(300, 100, 100, 40, 15, 10, 0);

    @(negedge clk);
    applyReset(2);
    runPhase(400, 50, 70, 50, 8, 10, 2);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
